wave_gen: RTL and testbench

WAVE_GEN -- requirements
Module: wave_gen

---
 rtl/wave_gen.sv | 129 ++++++++++++
 tb/tb_wave_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen.sv
// Tone generator: one sample per 2^N-clock PWM period from a phase accumulator, shaped and scaled by an AR envelope.
// Latency: sample registered on the tick edge, sample_vld strobes the following cycle; no backpressure, ena=0 freezes everything.
module wave_gen #(
    parameter int N        = 8,
    parameter int PW       = 16,
    parameter int ENV_STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         gate,
    input  logic [7:0]   freq,
    input  logic [1:0]   wave,
    output logic [N-1:0] sample,
    output logic         sample_vld,
    output logic [1:0]   env_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ATTACK  = 2'b01,
        S_SUSTAIN = 2'b10,
        S_RELEASE = 2'b11
    } env_st_e;

    localparam logic [N-1:0] FULL = {N{1'b1}};
    localparam logic [N:0]   STEP = (N+1)'(ENV_STEP);

    logic [N-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [N-1:0]   env_q, env_d;
    env_st_e        st_q, st_d;
    logic [N-1:0]   sample_q, sample_d;
    logic           vld_q;

    logic           tick;
    logic [N-1:0]   p;
    logic [N-1:0]   tri_t;
    logic [N-1:0]   raw;
    logic [2*N-1:0] prod;
    logic [N:0]     env_sum;
    logic           unused_prod_lo;

    assign tick  = ena && (cnt_q == FULL);
    assign p     = phase_q[PW-1 -: N];
    assign tri_t = {p[N-2:0], 1'b0};

    always_comb begin
        raw = '0;
        case (wave)
            2'b00:   raw = p[N-1] ? FULL : '0;
            2'b01:   raw = p;
            2'b10:   raw = p[N-1] ? ~tri_t : tri_t;
            default: raw = '0;
        endcase
    end

    // Product uses the pre-tick phase and envelope; only the top half reaches the DAC.
    assign prod           = {{N{1'b0}}, raw} * {{N{1'b0}}, env_q};
    assign unused_prod_lo = ^prod[N-1:0];

    always_comb begin
        cnt_d    = ena  ? cnt_q + N'(1)         : cnt_q;
        phase_d  = tick ? phase_q + PW'(freq)   : phase_q;
        sample_d = tick ? prod[2*N-1:N]         : sample_q;
    end

    always_comb begin
        st_d    = st_q;
        env_d   = env_q;
        env_sum = {1'b0, env_q} + STEP;
        if (tick) begin
            case (st_q)
                S_IDLE: begin
                    env_d = '0;
                    if (gate) st_d = S_ATTACK;
                end
                S_ATTACK: begin
                    if (!gate) begin
                        st_d = S_RELEASE;
                    end else if (env_sum >= {1'b0, FULL}) begin
                        env_d = FULL;
                        st_d  = S_SUSTAIN;
                    end else begin
                        env_d = env_sum[N-1:0];
                    end
                end
                S_SUSTAIN: begin
                    env_d = FULL;
                    if (!gate) st_d = S_RELEASE;
                end
                S_RELEASE: begin
                    // A retrigger resumes the attack from wherever the release had got to.
                    if (gate) begin
                        st_d = S_ATTACK;
                    end else if ({1'b0, env_q} <= STEP) begin
                        env_d = '0;
                        st_d  = S_IDLE;
                    end else begin
                        env_d = env_q - STEP[N-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            phase_q  <= '0;
            env_q    <= '0;
            st_q     <= S_IDLE;
            sample_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            env_q    <= env_d;
            st_q     <= st_d;
            sample_q <= sample_d;
            vld_q    <= tick;
        end
    end

    assign sample     = sample_q;
    assign sample_vld = vld_q;
    assign env_state  = st_q;

endmodule

// File: tb/tb_wave_gen.sv
// Bench for wave_gen: hand-derived vector table on 8-bit instances plus a random run on 4-bit instances against a reference model.
module tb_wave_gen;

    logic       clk;
    logic       rst_n, ena, gate;
    logic [7:0] freq;
    logic [1:0] wave_a, wave_b;
    logic [7:0] sample_a, sample_b;
    logic       sample_vld_a, sample_vld_b;
    logic [1:0] env_state_a, env_state_b;

    logic       rst_s_n, ena_s, gate_s;
    logic [7:0] freq_s;
    logic [1:0] wave_s;
    logic [3:0] sample_c, sample_d;
    logic       sample_vld_c, sample_vld_d;
    logic [1:0] env_state_c, env_state_d;

    int n_pass = 0;
    int n_tot  = 0;

    wave_gen #(.N(8), .PW(16), .ENV_STEP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .gate(gate), .freq(freq), .wave(wave_a),
        .sample(sample_a), .sample_vld(sample_vld_a), .env_state(env_state_a));
    wave_gen #(.N(8), .PW(16), .ENV_STEP(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .gate(gate), .freq(freq), .wave(wave_b),
        .sample(sample_b), .sample_vld(sample_vld_b), .env_state(env_state_b));
    wave_gen #(.N(4), .PW(12), .ENV_STEP(1)) dut_c (
        .clk(clk), .rst_n(rst_s_n), .ena(ena_s), .gate(gate_s), .freq(freq_s), .wave(wave_s),
        .sample(sample_c), .sample_vld(sample_vld_c), .env_state(env_state_c));
    wave_gen #(.N(4), .PW(12), .ENV_STEP(4)) dut_d (
        .clk(clk), .rst_n(rst_s_n), .ena(ena_s), .gate(gate_s), .freq(freq_s), .wave(wave_s),
        .sample(sample_d), .sample_vld(sample_vld_d), .env_state(env_state_d));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    localparam int ST_IDLE = 0, ST_ATTACK = 1, ST_SUSTAIN = 2, ST_RELEASE = 3;

    typedef struct {
        int cnt;
        int phase;
        int env;
        int st;
        int smp;
        int vld;
    } mdl_t;

    function automatic mdl_t mstep(mdl_t m, int n, int pw, int step,
                                   bit en, bit g, int f, int w);
        mdl_t r;
        int full, half, p, raw;
        r     = m;
        r.vld = 0;
        full  = (1 << n) - 1;
        half  = 1 << (n - 1);
        if (!en) return r;
        r.cnt = (m.cnt + 1) % (1 << n);
        if (m.cnt == full) begin
            r.vld = 1;
            p = m.phase >> (pw - n);
            case (w)
                0:       raw = (p >= half) ? full : 0;
                1:       raw = p;
                2:       raw = (p < half) ? 2 * p : full - 2 * (p - half);
                default: raw = 0;
            endcase
            r.smp   = (raw * m.env) >> n;
            r.phase = (m.phase + f) % (1 << pw);
            case (m.st)
                ST_IDLE:    if (g) r.st = ST_ATTACK;
                ST_ATTACK:  if (!g) r.st = ST_RELEASE;
                            else if (m.env + step >= full) begin r.env = full; r.st = ST_SUSTAIN; end
                            else r.env = m.env + step;
                ST_SUSTAIN: if (!g) r.st = ST_RELEASE;
                default:    if (g) r.st = ST_ATTACK;
                            else if (m.env <= step) begin r.env = 0; r.st = ST_IDLE; end
                            else r.env = m.env - step;
            endcase
        end
        return r;
    endfunction

    mdl_t m_a, m_b, m_c, m_d, m_zero;

    // Every cycle, all four instances are compared against the model.
    initial begin
        m_zero = '{default: 0};
        m_a = m_zero; m_b = m_zero; m_c = m_zero; m_d = m_zero;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_a = m_zero; m_b = m_zero;
            end else begin
                m_a = mstep(m_a, 8, 16, 1,   ena, gate, int'(freq), int'(wave_a));
                m_b = mstep(m_b, 8, 16, 255, ena, gate, int'(freq), int'(wave_b));
            end
            if (!rst_s_n) begin
                m_c = m_zero; m_d = m_zero;
            end else begin
                m_c = mstep(m_c, 4, 12, 1, ena_s, gate_s, int'(freq_s), int'(wave_s));
                m_d = mstep(m_d, 4, 12, 4, ena_s, gate_s, int'(freq_s), int'(wave_s));
            end
            #1;
            chk("mon_a", int'({env_state_a, sample_vld_a, sample_a}), m_a.st * 512 + m_a.vld * 256 + m_a.smp);
            chk("mon_b", int'({env_state_b, sample_vld_b, sample_b}), m_b.st * 512 + m_b.vld * 256 + m_b.smp);
            chk("mon_c", int'({env_state_c, sample_vld_c, sample_c}), m_c.st * 32 + m_c.vld * 16 + m_c.smp);
            chk("mon_d", int'({env_state_d, sample_vld_d, sample_d}), m_d.st * 32 + m_d.vld * 16 + m_d.smp);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_tick(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!sample_vld_a && edges < 300);
        if (!sample_vld_a) chk("tick_a_timeout", 0, 1);
    endtask

    task automatic wait_tick_s(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!sample_vld_c && edges < 40);
        if (!sample_vld_c) chk("tick_c_timeout", 0, 1);
    endtask

    typedef struct {
        bit         g;
        logic [1:0] wa;
        logic [1:0] wb;
        logic [7:0] f;
        int         ticks;
        int         st_a;
        int         smp_a;
        int         st_b;
        int         smp_b;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // gate, wave_a, wave_b, freq, ticks to run, A state/sample, B state/sample after the last tick
        tbl[0] = '{1'b1, 2'b01, 2'b00, 8'h80,   1, 1,   0, 1,   0};  // tick 1
        tbl[1] = '{1'b1, 2'b01, 2'b00, 8'h80,   1, 1,   0, 2,   0};  // tick 2
        tbl[2] = '{1'b1, 2'b01, 2'b00, 8'h80, 198, 1,  76, 2,   0};  // tick 200
        tbl[3] = '{1'b1, 2'b01, 2'b00, 8'h80,  55, 1, 125, 2,   0};  // tick 255
        tbl[4] = '{1'b1, 2'b01, 2'b00, 8'h80,   1, 2, 126, 2,   0};  // tick 256
        tbl[5] = '{1'b1, 2'b01, 2'b00, 8'h80,   1, 2, 127, 2, 254};  // tick 257
        tbl[6] = '{1'b1, 2'b10, 2'b00, 8'h80,   1, 2, 254, 2, 254};  // tick 258
        tbl[7] = '{1'b1, 2'b11, 2'b00, 8'h80,   1, 2,   0, 2, 254};  // tick 259
        tbl[8] = '{1'b1, 2'b01, 2'b00, 8'h80,   1, 2, 128, 2, 254};  // tick 260

        rst_n = 1'b0; ena = 1'b0; gate = 1'b0; freq = 8'h00; wave_a = 2'b01; wave_b = 2'b00;
        rst_s_n = 1'b0; ena_s = 1'b0; gate_s = 1'b0; freq_s = 8'h00; wave_s = 2'b00;

        fork
            begin : dir_a
                int e, nv;
                repeat (3) @(negedge clk);
                chk("rst_sample_a", int'(sample_a), 0);
                chk("rst_vld_a",    int'(sample_vld_a), 0);
                chk("rst_state_a",  int'(env_state_a), 0);
                rst_n = 1'b1; ena = 1'b1;
                for (int i = 0; i < 9; i++) begin
                    gate = tbl[i].g; wave_a = tbl[i].wa; wave_b = tbl[i].wb; freq = tbl[i].f;
                    for (int k = 0; k < tbl[i].ticks; k++) begin
                        wait_tick(e);
                        chk("tick_period_a", e, 256);
                    end
                    chk($sformatf("vec%0d_state_a", i),  int'(env_state_a), tbl[i].st_a);
                    chk($sformatf("vec%0d_sample_a", i), int'(sample_a),    tbl[i].smp_a);
                    chk($sformatf("vec%0d_state_b", i),  int'(env_state_b), tbl[i].st_b);
                    chk($sformatf("vec%0d_sample_b", i), int'(sample_b),    tbl[i].smp_b);
                end
                // Freeze 100 clocks into the period; gate wiggles while frozen must be ignored.
                repeat (100) @(negedge clk);
                ena = 1'b0; gate = 1'b0;
                nv = 0;
                repeat (1000) begin
                    @(negedge clk);
                    if (sample_vld_a) nv++;
                end
                chk("pause_vld_a",    nv, 0);
                chk("pause_sample_a", int'(sample_a), 128);
                chk("pause_state_a",  int'(env_state_a), 2);
                chk("pause_sample_b", int'(sample_b), 254);
                gate = 1'b1; ena = 1'b1;
                wait_tick(e);
                chk("resume_edges_a",  e, 156);
                chk("resume_sample_a", int'(sample_a), 129);
                chk("resume_state_a",  int'(env_state_a), 2);
                // Asynchronous reset in the strobe cycle, mid-sustain.
                #1 rst_n = 1'b0;
                #1;
                chk("arst_sample_a", int'(sample_a), 0);
                chk("arst_vld_a",    int'(sample_vld_a), 0);
                chk("arst_state_a",  int'(env_state_a), 0);
                chk("arst_sample_b", int'(sample_b), 0);
                chk("arst_state_b",  int'(env_state_b), 0);
                gate = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                wait_tick(e);
                chk("post_rst_edges_a",  e, 256);
                chk("post_rst_state_a",  int'(env_state_a), 0);
                chk("post_rst_sample_a", int'(sample_a), 0);
            end
            begin : dir_s
                int e, tc, td, ns, nz;
                repeat (3) @(negedge clk);
                rst_s_n = 1'b1; ena_s = 1'b1; gate_s = 1'b1; freq_s = 8'($urandom);
                repeat (16) begin
                    wait_tick_s(e);
                    chk("tick_period_c", e, 16);
                end
                chk("sus_state_c", int'(env_state_c), 2);
                chk("sus_state_d", int'(env_state_d), 2);
                gate_s = 1'b0;
                wait_tick_s(e);
                chk("rel_state_c", int'(env_state_c), 3);
                chk("rel_state_d", int'(env_state_d), 3);
                tc = -1; td = -1;
                for (int j = 1; j <= 40 && (tc < 0 || td < 0); j++) begin
                    wait_tick_s(e);
                    if (tc < 0 && env_state_c == 2'd0) tc = j;
                    if (td < 0 && env_state_d == 2'd0) td = j;
                end
                chk("rel_ticks_c", tc, 15);
                chk("rel_ticks_d", td, 4);
                gate_s = 1'b1;
                repeat (16) wait_tick_s(e);
                chk("resus_state_c", int'(env_state_c), 2);
                gate_s = 1'b0;
                repeat (5) wait_tick_s(e);
                chk("rerel_state_c", int'(env_state_c), 3);
                gate_s = 1'b1;
                wait_tick_s(e);
                chk("retrig_state_c", int'(env_state_c), 1);
                ns = 0; nz = 0;
                for (int j = 1; j <= 10 && ns == 0; j++) begin
                    wait_tick_s(e);
                    if (env_state_c == 2'd0) nz++;
                    if (env_state_c == 2'd2) ns = j;
                end
                chk("retrig_ticks_c", ns, 4);
                chk("retrig_no_idle_c", nz, 0);
                for (int i = 0; i < 50000; i++) begin
                    @(negedge clk);
                    if ($urandom_range(0, 149) == 0) gate_s = ~gate_s;
                    if ($urandom_range(0, 199) == 0) wave_s = 2'($urandom);
                    if ($urandom_range(0, 199) == 0) freq_s = 8'($urandom);
                    ena_s   = ($urandom_range(0, 15) != 0);
                    rst_s_n = ($urandom_range(0, 4999) != 0);
                end
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
